id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Interlock and flush controller for the five-stage pipeline around the decode stage. Each cycle it compares the instruction in IF/ID against a 3-entry scoreboard of in-flight destination registers (EX, MEM, WB), then drives the stall, bubble and flush strobes for the PC, IF/ID, ID/EX and EX/MEM latches. It also handles taken-branch squashes and global freezes on memory-busy, and keeps stall/flush performance counters plus a stall watchdog.

## Interface
- FORWARDING, 1, 1: the EX/MEM forwarding unit exists, so only load-use hazards stall; 0: any pending write to a source register stalls.
- MAX_STALL, 8, consecutive hazard-stall cycles tolerated before `stall_timeout` sets.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs, id_rt  in  5 each  source register fields (instr[25:21], instr[20:16]).
- id_uses_rs, id_uses_rt  in  1 each  instruction actually reads that source.
- id_reg_write  in  1  instruction writes a register (control WB bit).
- id_mem_read  in  1  instruction is a load.
- id_dest  in  5  resolved destination (rt or rd after RegDst).
- mem_branch_taken  in  1  branch in MEM resolved taken.
- mem_busy  in  1  data/instruction memory not ready; freeze the whole pipeline.
- pc_write, if_id_write  out  1 each  enable the PC and IF/ID latches.
- id_ex_bubble  out  1  load zero WB/MEM/EX controls into ID/EX.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  squash the latch contents.
- pipe_freeze  out  1  hold every pipeline latch.
- hazard_stall_count, flush_count  out  32 each  saturating performance counters.
- stall_timeout  out  1  sticky watchdog flag.

## Operation
- Each scoreboard entry holds {valid, dest[4:0], load}; it mirrors the EX, MEM and WB occupants.
- A source is live when `id_valid`, its use bit is set, and the register is nonzero. Register 0 never hazards.
- When FORWARDING=1, `hz` = a live source equals the EX dest, and the EX entry is valid and a load.
- When FORWARDING=0, `hz` = a live source equals any valid EX, MEM or WB dest. The regfile has no write-through.
- Priority 1, `mem_busy`:
  - `pipe_freeze`=1, `pc_write`=`if_id_write`=0.
  - Bubble and flush outputs are 0.
  - Scoreboard and the stall watchdog counter hold.
- Priority 2, `mem_branch_taken`:
  - All three flush outputs = 1, `pc_write`=1, `if_id_write`=1.
  - Next-state scoreboard: EX = invalid, MEM = invalid, WB ← MEM.
  - `flush_count` increments.
- Priority 3, `hz`:
  - `pc_write`=`if_id_write`=0, `id_ex_bubble`=1.
  - Next-state scoreboard: EX = invalid, MEM ← EX, WB ← MEM.
  - `hazard_stall_count` increments.
- Otherwise: all enables = 1, strobes = 0. Shift WB ← MEM, MEM ← EX, EX ← {id_valid & id_reg_write, id_dest, id_mem_read}.
- FSM states:
  - RUN → STALL on `hz` without branch or busy.
  - RUN or STALL → FRZ on `mem_busy`.
  - FRZ → RUN when `mem_busy` drops.
  - STALL → RUN when `hz` clears or on a branch.
- Stall-run counter (width $clog2(MAX_STALL+1)):
  - Counts cycles in STALL.
  - Clears in RUN.
  - Holds in FRZ.
  - When it reaches MAX_STALL, `stall_timeout` sets and stays set until `rst`.
- Counters saturate at 32'hFFFF_FFFF.

## Timing
- Strobes and enables are combinational from the current scoreboard and ID inputs (same-cycle). All state is registered.
- A load-use hazard costs exactly 1 bubble with FORWARDING=1, and up to 3 with FORWARDING=0.
- A branch squash costs 3 instructions.
- Simultaneous `hz` and `mem_branch_taken`: the branch wins and no stall is counted.
- Simultaneous `mem_busy` and either of the others: busy wins, and the branch is re-evaluated once busy drops.
- While `rst`=1:
  - `pc_write`=`if_id_write`=1.
  - All bubble, flush and freeze outputs = 0.
- After the reset edge: scoreboard invalid, state RUN, both counters 0, `stall_timeout`=0.
- Reset mid-stall or mid-freeze discards all state in one cycle.

## Structure
- Shared pipeline package holds:
  - the scoreboard entry struct {valid, dest, load};
  - the state enum {RUN, STALL, FRZ};
  - the REG_ZERO constant.
- The package is shared with the forwarding unit.
- One natural sub-module is `hazard_scoreboard`: the 3-entry shift/hold/invalidate register with match outputs. The priority logic, FSM and counters stay in the top.

## Test plan
- FORWARDING=1, load to r8 in EX, ID reads r8 via rs → exactly one cycle with `id_ex_bubble`=1 and `pc_write`=0; `hazard_stall_count`=1.
- FORWARDING=0, ALU write r5 followed by a reader of r5 → 3 stall cycles.
- Same as previous with dest r0 → 0 stall cycles.
- `mem_branch_taken` asserted together with a load-use `hz` → all three flushes = 1, no bubble; `flush_count`=1, `hazard_stall_count` unchanged.
- `mem_busy` for 4 cycles during a load-use stall → `pipe_freeze`=1 throughout, scoreboard held; the stall completes after busy drops.
- MAX_STALL=2, FORWARDING=0, a three-cycle dependency → `stall_timeout` sets and stays set.
- Assert `rst` mid-stall → outputs return to their reset values and the counters read 0 after the edge.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the decode-stage hazard logic and the forwarding unit.
package id_hazard_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // One in-flight destination: EX, MEM or WB occupant
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       load;
  } sb_entry_t;

  typedef enum logic [1:0] {RUN, STALL, FRZ} hz_state_t;

  // Scoreboard update for the coming edge
  typedef enum logic [1:0] {SB_SHIFT, SB_HOLD, SB_BUBBLE, SB_SQUASH} sb_op_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// 3-entry scoreboard (EX, MEM, WB) of pending register writes, with per-stage
// source-match outputs for the instruction sitting in IF/ID.
module hazard_scoreboard
  import id_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  sb_op_t     op,
  input  sb_entry_t  new_entry,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       rs_live,
  input  logic       rt_live,
  output logic       ex_hit,
  output logic       mem_hit,
  output logic       wb_hit,
  output logic       ex_load
);

  sb_entry_t ex, mem, wb;

  // Shift on normal flow, hold on freeze, bubble into EX on stall, squash on branch
  always_ff @(posedge clk) begin
    if (rst) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      case (op)
        SB_HOLD: begin
          ex  <= ex;
          mem <= mem;
          wb  <= wb;
        end
        SB_SQUASH: begin
          wb  <= mem;
          mem <= '0;
          ex  <= '0;
        end
        SB_BUBBLE: begin
          wb  <= mem;
          mem <= ex;
          ex  <= '0;
        end
        default: begin
          wb  <= mem;
          mem <= ex;
          ex  <= new_entry;
        end
      endcase
    end
  end

  // A stage matches when it is valid and a live source names its destination
  always_comb begin
    ex_hit  = ex.valid  && ((rs_live && rs == ex.dest)  || (rt_live && rt == ex.dest));
    mem_hit = mem.valid && ((rs_live && rs == mem.dest) || (rt_live && rt == mem.dest));
    wb_hit  = wb.valid  && ((rs_live && rs == wb.dest)  || (rt_live && rt == wb.dest));
    ex_load = ex.valid && ex.load;
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage interlock/flush controller: priority busy > branch > hazard,
// FSM tracking RUN/STALL/FRZ, saturating perf counters and a stall watchdog.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter bit FORWARDING = 1'b1,
  parameter int MAX_STALL  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic [4:0]  id_dest,
  input  logic        mem_branch_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        pipe_freeze,
  output logic [31:0] hazard_stall_count,
  output logic [31:0] flush_count,
  output logic        stall_timeout
);

  localparam int            CW   = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_STALL);

  logic      rs_live, rt_live, hz;
  logic      ex_hit, mem_hit, wb_hit, ex_load;
  logic      stall_cyc, flush_cyc;
  sb_op_t    sb_op;
  sb_entry_t new_entry;
  hz_state_t state, state_nxt;
  logic [CW-1:0] stall_run, stall_run_nxt;

  assign rs_live   = id_valid && id_uses_rs && (id_rs != REG_ZERO);
  assign rt_live   = id_valid && id_uses_rt && (id_rt != REG_ZERO);
  assign new_entry = '{valid: id_valid && id_reg_write, dest: id_dest, load: id_mem_read};

  hazard_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .op        (sb_op),
    .new_entry (new_entry),
    .rs        (id_rs),
    .rt        (id_rt),
    .rs_live   (rs_live),
    .rt_live   (rt_live),
    .ex_hit    (ex_hit),
    .mem_hit   (mem_hit),
    .wb_hit    (wb_hit),
    .ex_load   (ex_load)
  );

  // With forwarding only a load in EX can't be bypassed; without it, and with
  // no regfile write-through, every pending writer blocks the read
  always_comb begin
    if (FORWARDING) hz = ex_hit && ex_load;
    else            hz = ex_hit || mem_hit || wb_hit;
  end

  // Priority decode of latch enables/strobes and the scoreboard update
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_freeze  = 1'b0;
    sb_op        = SB_SHIFT;
    stall_cyc    = 1'b0;
    flush_cyc    = 1'b0;
    if (rst) begin
      sb_op = SB_SHIFT;
    end else if (mem_busy) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      sb_op       = SB_HOLD;
    end else if (mem_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      sb_op        = SB_SQUASH;
      flush_cyc    = 1'b1;
    end else if (hz) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      sb_op        = SB_BUBBLE;
      stall_cyc    = 1'b1;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mem_busy) state_nxt = FRZ;
               else if (hz && !mem_branch_taken) state_nxt = STALL;
      STALL:   if (mem_busy) state_nxt = FRZ;
               else if (!hz || mem_branch_taken) state_nxt = RUN;
      FRZ:     if (!mem_busy) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Consecutive hazard-stall run length: freezes pause it, any non-stall cycle clears it
  always_comb begin
    stall_run_nxt = stall_run;
    if (mem_busy)              stall_run_nxt = stall_run;
    else if (!stall_cyc)       stall_run_nxt = '0;
    else if (stall_run != CMAX) stall_run_nxt = stall_run + CW'(1);
  end

  // Watchdog, run counter and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_run          <= '0;
      stall_timeout      <= 1'b0;
      hazard_stall_count <= '0;
      flush_count        <= '0;
    end else begin
      stall_run <= stall_run_nxt;
      if (stall_run_nxt == CMAX) stall_timeout <= 1'b1;
      if (stall_cyc && hazard_stall_count != 32'hFFFF_FFFF)
        hazard_stall_count <= hazard_stall_count + 32'd1;
      if (flush_cyc && flush_count != 32'hFFFF_FFFF)
        flush_count <= flush_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench: two controllers (forwarding / no forwarding with a short watchdog) share
// one IF/ID input stream and are checked against an in-flight-write model.
module tb_id_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       id_valid = 0, id_uses_rs = 0, id_uses_rt = 0, id_reg_write = 0, id_mem_read = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_dest = 0;
  logic       br = 0, busy = 0;

  logic        pcw [2], ifw [2], bub [2], iff_o [2], idf [2], exf [2], frz [2], tmo [2];
  logic [31:0] hsc [2], fc [2];

  id_hazard_ctrl #(.FORWARDING(1'b1), .MAX_STALL(8)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_dest(id_dest), .mem_branch_taken(br), .mem_busy(busy),
    .pc_write(pcw[0]), .if_id_write(ifw[0]), .id_ex_bubble(bub[0]), .if_id_flush(iff_o[0]),
    .id_ex_flush(idf[0]), .ex_mem_flush(exf[0]), .pipe_freeze(frz[0]),
    .hazard_stall_count(hsc[0]), .flush_count(fc[0]), .stall_timeout(tmo[0]));

  id_hazard_ctrl #(.FORWARDING(1'b0), .MAX_STALL(2)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_dest(id_dest), .mem_branch_taken(br), .mem_busy(busy),
    .pc_write(pcw[1]), .if_id_write(ifw[1]), .id_ex_bubble(bub[1]), .if_id_flush(iff_o[1]),
    .id_ex_flush(idf[1]), .ex_mem_flush(exf[1]), .pipe_freeze(frz[1]),
    .hazard_stall_count(hsc[1]), .flush_count(fc[1]), .stall_timeout(tmo[1]));

  int checks = 0;
  int errors = 0;

  // Reference model: the writes still in flight, oldest last, per controller
  bit  fwd_m [2] = '{1'b1, 1'b0};
  int  max_m [2] = '{8, 2};
  bit  fl_v [2][3];
  int  fl_d [2][3];
  bit  fl_l [2][3];
  longint n_stall [2], n_flush [2];
  int  run_len [2];
  bit  tout_m [2];
  bit  hz_m [2];
  int  nbub [2], nfrz [2], nfl [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit src_reads(input int r);
    return id_valid && r != 0 &&
           ((id_uses_rs && int'(id_rs) == r) || (id_uses_rt && int'(id_rt) == r));
  endfunction

  // Does the decoding instruction have to wait on some in-flight write?
  function automatic bit model_hz(input int d);
    bit h = 0;
    for (int s = 0; s < 3; s++) begin
      if (fl_v[d][s] && src_reads(fl_d[d][s])) begin
        // with bypassing, only a load still one stage ahead is unavailable
        if (!fwd_m[d] || (s == 0 && fl_l[d][s])) h = 1;
      end
    end
    return h;
  endfunction

  task automatic model_edge(input int d);
    if (rst) begin
      for (int s = 0; s < 3; s++) fl_v[d][s] = 0;
      n_stall[d] = 0; n_flush[d] = 0; run_len[d] = 0; tout_m[d] = 0;
    end else if (busy) begin
      // everything frozen
    end else if (br) begin
      fl_v[d][2] = fl_v[d][1]; fl_d[d][2] = fl_d[d][1]; fl_l[d][2] = fl_l[d][1];
      fl_v[d][1] = 0; fl_v[d][0] = 0;
      if (n_flush[d] < 64'hFFFF_FFFF) n_flush[d]++;
      run_len[d] = 0;
    end else begin
      fl_v[d][2] = fl_v[d][1]; fl_d[d][2] = fl_d[d][1]; fl_l[d][2] = fl_l[d][1];
      fl_v[d][1] = fl_v[d][0]; fl_d[d][1] = fl_d[d][0]; fl_l[d][1] = fl_l[d][0];
      if (hz_m[d]) begin
        fl_v[d][0] = 0;
        if (n_stall[d] < 64'hFFFF_FFFF) n_stall[d]++;
        run_len[d]++;
        if (run_len[d] >= max_m[d]) tout_m[d] = 1;
      end else begin
        fl_v[d][0] = id_valid && id_reg_write; fl_d[d][0] = int'(id_dest); fl_l[d][0] = id_mem_read;
        run_len[d] = 0;
      end
    end
  endtask

  // One clock: check strobes mid-cycle, advance model on the edge, check state after it
  task automatic cyc();
    logic [6:0] e, o;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      hz_m[d] = model_hz(d);
      if (rst)            e = 7'b1100000;
      else if (busy)      e = 7'b0000001;
      else if (br)        e = 7'b1101110;
      else if (hz_m[d])   e = 7'b0010000;
      else                e = 7'b1100000;
      o = {pcw[d], ifw[d], bub[d], iff_o[d], idf[d], exf[d], frz[d]};
      chk($sformatf("strobes%0d", d), 32'(o), 32'(e));
      nbub[d] += int'(bub[d]);
      nfrz[d] += int'(frz[d]);
      nfl[d]  += int'(iff_o[d] & idf[d] & exf[d]);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("stall_cnt%0d", d), hsc[d], 32'(n_stall[d]));
      chk($sformatf("flush_cnt%0d", d), fc[d], 32'(n_flush[d]));
      chk($sformatf("timeout%0d", d), 32'(tmo[d]), 32'(tout_m[d]));
    end
  endtask

  task automatic set_id(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                        input bit wr, input bit ld, input int dst);
    id_valid = v; id_rs = 5'(rs); id_uses_rs = urs; id_rt = 5'(rt); id_uses_rt = urt;
    id_reg_write = wr; id_mem_read = ld; id_dest = 5'(dst);
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clr_tally();
    for (int d = 0; d < 2; d++) begin nbub[d] = 0; nfrz[d] = 0; nfl[d] = 0; end
  endtask

  task automatic do_reset();
    rst = 1; br = 0; busy = 0; idle(); cyc(); rst = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_hsc%0d", d), hsc[d], 0);
      chk($sformatf("rst_tmo%0d", d), 32'(tmo[d]), 0);
    end

    // load r8, then a reader of r8 held in IF/ID
    clr_tally();
    set_id(1, 0, 0, 0, 0, 1, 1, 8); cyc();
    set_id(1, 8, 1, 0, 0, 0, 0, 0); repeat (5) cyc();
    idle(); cyc();
    chk("lu_bub_fwd", nbub[0], 1);
    chk("lu_bub_nofwd", nbub[1], 3);
    chk("lu_hsc_fwd", hsc[0], 1);
    chk("lu_tmo_nofwd", 32'(tmo[1]), 1);
    chk("lu_tmo_fwd", 32'(tmo[0]), 0);

    // ALU write r5, reader via rt; watchdog must stay set
    clr_tally();
    set_id(1, 0, 0, 0, 0, 1, 0, 5); cyc();
    set_id(1, 0, 0, 5, 1, 0, 0, 0); repeat (5) cyc();
    idle(); cyc();
    chk("alu_bub_fwd", nbub[0], 0);
    chk("alu_bub_nofwd", nbub[1], 3);
    chk("alu_tmo_sticky", 32'(tmo[1]), 1);

    // write to r0 never interlocks
    clr_tally();
    set_id(1, 0, 0, 0, 0, 1, 0, 0); cyc();
    set_id(1, 0, 1, 0, 1, 0, 0, 0); repeat (4) cyc();
    idle(); cyc();
    chk("r0_bub_fwd", nbub[0], 0);
    chk("r0_bub_nofwd", nbub[1], 0);

    // branch coincident with load-use: branch wins
    do_reset(); clr_tally();
    set_id(1, 0, 0, 0, 0, 1, 1, 8); cyc();
    set_id(1, 8, 1, 0, 0, 0, 0, 0); br = 1; cyc();
    br = 0; idle(); repeat (2) cyc();
    chk("br_flush_fwd", nfl[0], 1);
    chk("br_bub_fwd", nbub[0], 0);
    chk("br_fc_fwd", fc[0], 1);
    chk("br_hsc_fwd", hsc[0], 0);

    // freeze for 4 cycles over a load-use stall
    do_reset(); clr_tally();
    set_id(1, 0, 0, 0, 0, 1, 1, 8); cyc();
    set_id(1, 8, 1, 0, 0, 0, 0, 0); busy = 1; repeat (4) cyc();
    busy = 0; repeat (2) cyc();
    idle(); cyc();
    chk("busy_frz_fwd", nfrz[0], 4);
    chk("busy_bub_fwd", nbub[0], 1);
    chk("busy_hsc_fwd", hsc[0], 1);

    // reset in the middle of a stall
    set_id(1, 0, 0, 0, 0, 1, 0, 5); cyc();
    set_id(1, 5, 1, 0, 0, 0, 0, 0); cyc();
    rst = 1; cyc();
    rst = 0; idle();
    chk("midrst_hsc_nofwd", hsc[1], 0);
    chk("midrst_tmo_nofwd", 32'(tmo[1]), 0);
    cyc();

    // randomized traffic on a small register set to keep hazards frequent
    repeat (600) begin
      rst  = ($urandom_range(0, 59) == 0);
      busy = ($urandom_range(0, 9) == 0);
      br   = ($urandom_range(0, 11) == 0);
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1) != 0,
             $urandom_range(0, 3), $urandom_range(0, 1) != 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 3));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
